// File: rtl/vdg_pkg.sv
// Shared VDG pipeline types and helpers.
// Used by the pixel shifter and the colour mapping stage.
package vdg_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    STARVED = 2'd2
  } state_t;

  localparam int SLOTS_PER_BYTE = 8;

  function automatic logic is_colour_graphics(
    input logic       ang,
    input logic [2:0] mode
  );
    return ang & ~mode[0];
  endfunction

endpackage

// File: rtl/pixel_select.sv
// Picks the 2-bit pixel for a slot of the shift byte, MSB first.
// Colour graphics uses bit pairs held for two slots each.
module pixel_select
  import vdg_pkg::*;
(
  input  logic [7:0] shift,
  input  logic [2:0] slot,
  input  logic       ang,
  input  logic [2:0] mode,
  output logic [1:0] pixel
);

  logic [7:0] shl;

  always_comb begin
    shl   = 8'h00;
    pixel = 2'b00;
    if (is_colour_graphics(ang, mode)) begin
      shl   = shift << {slot[2:1], 1'b0};
      pixel = shl[7:6];
    end else begin
      shl   = shift << slot;
      pixel = {1'b0, shl[7]};
    end
  end

endmodule

// File: rtl/pixel_shifter.sv
// Serialises fetched bytes into the 2-bit pixel stream with one
// byte of double buffering and an underrun indication.
module pixel_shifter
  import vdg_pkg::*;
(
  input  logic       Clk,
  input  logic       nReset,
  input  logic       PixEn,
  input  logic       Blank,
  input  logic [7:0] Data,
  input  logic [2:0] ModeIn,
  input  logic       AnGIn,
  input  logic       CssIn,
  input  logic       Load,
  output logic       ByteReq,
  output logic [1:0] Pixel,
  output logic       PixelValid,
  output logic [2:0] Mode,
  output logic       AnG,
  output logic       Css,
  output logic       Underrun
);

  state_t     state_q, state_d;
  logic [2:0] slot_q, slot_d;
  logic [7:0] sh_q, sh_d;
  logic [2:0] mode_d;
  logic       ang_d, css_d;
  logic [1:0] pix_d, sel;
  logic       pv_d, und_d;
  logic       xfer;

  logic [7:0] hold_data;
  logic [2:0] hold_mode;
  logic       hold_ang, hold_css;

  // ByteReq doubles as the holding-register empty flag
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      ByteReq   <= 1'b1;
      hold_data <= 8'h00;
      hold_mode <= 3'b000;
      hold_ang  <= 1'b0;
      hold_css  <= 1'b0;
    end else if (xfer) begin
      ByteReq <= 1'b1;
    end else if (Load && ByteReq) begin
      ByteReq   <= 1'b0;
      hold_data <= Data;
      hold_mode <= ModeIn;
      hold_ang  <= AnGIn;
      hold_css  <= CssIn;
    end
  end

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    sh_d    = sh_q;
    mode_d  = Mode;
    ang_d   = AnG;
    css_d   = Css;
    und_d   = 1'b0;
    xfer    = 1'b0;
    if (Blank) begin
      state_d = IDLE;
      slot_d  = 3'd0;
      sh_d    = 8'h00;
    end else if (PixEn) begin
      slot_d = (state_q == IDLE) ? 3'd0 : slot_q + 3'd1;
      // IDLE leaves on a byte boundary too
      if (state_q == IDLE || slot_q == 3'(SLOTS_PER_BYTE - 1)) begin
        if (!ByteReq) begin
          xfer    = 1'b1;
          state_d = RUN;
          sh_d    = hold_data;
          mode_d  = hold_mode;
          ang_d   = hold_ang;
          css_d   = hold_css;
        end else begin
          state_d = STARVED;
          und_d   = 1'b1;
        end
      end
    end
  end

  pixel_select u_sel (
    .shift (sh_d),
    .slot  (slot_d),
    .ang   (ang_d),
    .mode  (mode_d),
    .pixel (sel)
  );

  always_comb begin
    pix_d = Pixel;
    pv_d  = PixelValid;
    if (Blank) begin
      pix_d = 2'b00;
      pv_d  = 1'b0;
    end else if (PixEn) begin
      pv_d  = 1'b1;
      pix_d = (state_d == RUN) ? sel : 2'b00;
    end
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q    <= IDLE;
      slot_q     <= 3'd0;
      sh_q       <= 8'h00;
      Pixel      <= 2'b00;
      PixelValid <= 1'b0;
      Mode       <= 3'b000;
      AnG        <= 1'b0;
      Css        <= 1'b0;
      Underrun   <= 1'b0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      sh_q       <= sh_d;
      Pixel      <= pix_d;
      PixelValid <= pv_d;
      Mode       <= mode_d;
      AnG        <= ang_d;
      Css        <= css_d;
      Underrun   <= und_d;
    end
  end

endmodule

// File: tb/tb_pixel_shifter.sv
// Directed, table-driven bench for pixel_shifter.
module tb_pixel_shifter;

  logic       Clk = 1'b0;
  logic       nReset = 1'b0;
  logic       PixEn = 1'b0;
  logic       Blank = 1'b1;
  logic [7:0] Data = 8'h00;
  logic [2:0] ModeIn = 3'b000;
  logic       AnGIn = 1'b0;
  logic       CssIn = 1'b0;
  logic       Load = 1'b0;
  logic       ByteReq;
  logic [1:0] Pixel;
  logic       PixelValid;
  logic [2:0] Mode;
  logic       AnG;
  logic       Css;
  logic       Underrun;

  int checks = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  pixel_shifter dut (
    .Clk        (Clk),
    .nReset     (nReset),
    .PixEn      (PixEn),
    .Blank      (Blank),
    .Data       (Data),
    .ModeIn     (ModeIn),
    .AnGIn      (AnGIn),
    .CssIn      (CssIn),
    .Load       (Load),
    .ByteReq    (ByteReq),
    .Pixel      (Pixel),
    .PixelValid (PixelValid),
    .Mode       (Mode),
    .AnG        (AnG),
    .Css        (Css),
    .Underrun   (Underrun)
  );

  typedef struct {
    logic [7:0]  data;
    logic [2:0]  mode;
    logic        ang;
    logic        css;
    logic [15:0] px;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
               $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic load_byte(input logic [7:0] d, input logic [2:0] m,
                           input logic a, input logic c);
    Data   = d;
    ModeIn = m;
    AnGIn  = a;
    CssIn  = c;
    Load   = 1'b1;
  endtask

  task automatic chk_idle(input string name);
    chk({name, ".pix"}, 8'(Pixel), 8'h0);
    chk({name, ".pv"}, 8'(PixelValid), 8'h0);
  endtask

  initial begin
    vecs[0] = '{8'hB4, 3'b000, 1'b0, 1'b0, 16'b01_00_01_01_00_01_00_00};
    vecs[1] = '{8'h1B, 3'b000, 1'b1, 1'b1, 16'b00_00_01_01_10_10_11_11};
    vecs[2] = '{8'h1B, 3'b001, 1'b1, 1'b0, 16'b00_00_00_01_01_00_01_01};
    vecs[3] = '{8'hE4, 3'b010, 1'b1, 1'b1, 16'b11_11_10_10_01_01_00_00};

    tick();
    tick();
    chk("rst.breq", 8'(ByteReq), 8'h1);
    chk_idle("rst");
    chk("rst.mode", 8'(Mode), 8'h0);
    chk("rst.ang", 8'(AnG), 8'h0);
    chk("rst.css", 8'(Css), 8'h0);
    chk("rst.und", 8'(Underrun), 8'h0);
    nReset = 1'b1;
    tick();
    chk("rel.breq", 8'(ByteReq), 8'h1);
    chk_idle("rel");

    load_byte(vecs[0].data, vecs[0].mode, vecs[0].ang, vecs[0].css);
    tick();
    Load = 1'b0;
    chk("pre.breq", 8'(ByteReq), 8'h0);
    chk_idle("pre");

    Blank = 1'b0;
    PixEn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      for (int s = 0; s < 8; s++) begin
        // garbage loads while the holding register is full must drop
        if (s == 0 || (s == 5 && i < 3))
          load_byte(8'hFF, 3'b111, 1'b1, 1'b0);
        if (s == 3 && i < 3)
          load_byte(vecs[i+1].data, vecs[i+1].mode, vecs[i+1].ang,
                    vecs[i+1].css);
        tick();
        Load = 1'b0;
        chk($sformatf("v%0d.s%0d.pix", i, s), 8'(Pixel),
            8'(vecs[i].px[15-2*s -: 2]));
        chk("run.pv", 8'(PixelValid), 8'h1);
        chk("run.und", 8'(Underrun), 8'h0);
        chk($sformatf("v%0d.mode", i), 8'(Mode), 8'(vecs[i].mode));
        chk($sformatf("v%0d.ang", i), 8'(AnG), 8'(vecs[i].ang));
        chk($sformatf("v%0d.css", i), 8'(Css), 8'(vecs[i].css));
        if (s == 0) chk("xfer.breq", 8'(ByteReq), 8'h1);
        if (s == 3 && i < 3) chk("ld.breq", 8'(ByteReq), 8'h0);
        if (s == 4) begin
          PixEn = 1'b0;
          tick();
          PixEn = 1'b1;
          chk("hold.pix", 8'(Pixel), 8'(vecs[i].px[7:6]));
        end
      end
    end

    // starvation: slots 8..15, reload at slot 12
    for (int k = 0; k < 8; k++) begin
      if (k == 4) load_byte(8'h96, 3'b000, 1'b0, 1'b0);
      tick();
      Load = 1'b0;
      chk($sformatf("stv%0d.und", k), 8'(Underrun), (k == 0) ? 8'h1 : 8'h0);
      chk($sformatf("stv%0d.pix", k), 8'(Pixel), 8'h0);
      chk("stv.pv", 8'(PixelValid), 8'h1);
    end
    chk("stv.breq", 8'(ByteReq), 8'h0);
    tick();
    chk("s16.pix", 8'(Pixel), 8'h1);
    chk("s16.und", 8'(Underrun), 8'h0);
    chk("s16.breq", 8'(ByteReq), 8'h1);
    chk("s16.ang", 8'(AnG), 8'h0);
    tick();
    chk("s17.pix", 8'(Pixel), 8'h0);
    tick();
    chk("s18.pix", 8'(Pixel), 8'h0);

    Blank = 1'b1;
    tick();
    chk_idle("blank");
    tick();
    chk_idle("blank2");

    load_byte(8'h0F, 3'b000, 1'b0, 1'b0);
    tick();
    Load = 1'b0;
    Blank = 1'b0;
    for (int s = 0; s < 6; s++) begin
      tick();
      chk($sformatf("rs.s%0d.pix", s), 8'(Pixel), (s < 4) ? 8'h0 : 8'h1);
    end

    #2 nReset = 1'b0;
    #1;
    chk_idle("arst");
    chk("arst.breq", 8'(ByteReq), 8'h1);
    chk("arst.und", 8'(Underrun), 8'h0);
    Blank = 1'b1;
    @(negedge Clk);
    nReset = 1'b1;
    load_byte(8'hF0, 3'b001, 1'b1, 1'b1);
    tick();
    Load = 1'b0;
    Blank = 1'b0;
    tick();
    chk("ar.s0.pix", 8'(Pixel), 8'h1);
    chk("ar.mode", 8'(Mode), 8'h1);
    chk("ar.css", 8'(Css), 8'h1);
    chk("ar.und", 8'(Underrun), 8'h0);

    Blank = 1'b1;
    tick();
    chk_idle("b2");
    Blank = 1'b0;
    tick();
    chk("idstv.und", 8'(Underrun), 8'h1);
    chk("idstv.pv", 8'(PixelValid), 8'h1);
    chk("idstv.pix", 8'(Pixel), 8'h0);
    tick();
    chk("idstv2.und", 8'(Underrun), 8'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
